// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/halt control for a five-stage pipeline with performance counters
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_halt,
  input  logic             ex_memread,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             pc_sel_branch,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             dmem_req,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;
  logic mem_stall, load_use, stall_inc, flush_inc;
  assign mem_stall = mem_access & ~dmem_ready;
  assign load_use  = ex_memread & (ex_rd != '0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  always_comb begin
    state_d       = state_q;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;
    dmem_req      = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      state_d      = RUN;
    end else begin
      case (state_q)
        RUN: begin
          dmem_req = mem_access;
          if (mem_stall) begin
            mem_wb_en    = 1'b1;
            mem_wb_flush = 1'b1;
            stall_inc    = 1'b1;
          end else if (ex_branch_taken) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            flush_inc     = 1'b1;
          end else if (load_use) begin
            {id_ex_en, ex_mem_en, mem_wb_en} = '1;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end else begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            if_id_flush = id_halt;
            state_d     = id_halt ? DRAIN : RUN;
          end
        end
        DRAIN: begin
          // only bubbles trail the Halt, so branch and load-use inputs are ignored
          dmem_req     = mem_access;
          if_id_flush  = 1'b1;
          if_id_en     = ~mem_stall;
          id_ex_en     = ~mem_stall;
          ex_mem_en    = ~mem_stall;
          mem_wb_en    = 1'b1;
          mem_wb_flush = mem_stall;
          stall_inc    = mem_stall;
          state_d      = wb_halt ? HALTED : DRAIN;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    if (reset) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q != HALTED) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall_inc);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush_inc);
    end
  end
  assign halted    = (state_q == HALTED);
  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_halt, ex_memread, ex_branch_taken, mem_access, dmem_ready, wb_halt;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_sel_branch;
  logic if_id_flush, id_ex_flush, mem_wb_flush, dmem_req, halted;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [10:0] ctrl;
  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [10:0] ctrl;
    logic [31:0] cc, sc, fc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_halt(id_halt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .wb_halt(wb_halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .pc_sel_branch(pc_sel_branch), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush), .dmem_req(dmem_req),
    .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc,if_id,id_ex,ex_mem,mem_wb enables, pc_sel, if_id/id_ex/mem_wb flushes, dmem_req, halted}
  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_sel_branch,
                 if_id_flush, id_ex_flush, mem_wb_flush, dmem_req, halted};

  function automatic logic [10:0] mk(input logic [4:0] en, input logic sel,
                                     input logic [2:0] fl, input logic req, input logic h);
    return {en, sel, fl, req, h};
  endfunction

  localparam logic [10:0] RSTV = 11'b00000_0_111_0_0;
  localparam logic [10:0] NORM = 11'b11111_0_000_0_0;

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_halt = 0; ex_memread = 0;
    ex_branch_taken = 0; mem_access = 0; dmem_ready = 1; wb_halt = 0;
  endtask

  task automatic step(input string tag, input logic [10:0] c, input logic [31:0] cc,
                      input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    sb.push_back('{tag, c, cc, sc, fc});
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    assert (ctrl === e.ctrl) else begin
      fails++;
      $error("FAIL %s ctrl observed=%b expected=%b", e.tag, ctrl, e.ctrl);
    end
    tests++;
    assert ({cycle_cnt, stall_cnt, flush_cnt} === {e.cc, e.sc, e.fc}) else begin
      fails++;
      $error("FAIL %s counters observed=%0d/%0d/%0d expected=%0d/%0d/%0d", e.tag,
             cycle_cnt, stall_cnt, flush_cnt, e.cc, e.sc, e.fc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    reset = 1;
    mem_access = 1; dmem_ready = 0;
    @(posedge clk); #1;
    step("reset", RSTV, 0, 0, 0);
    reset = 0; clear_in();
    step("normal0", NORM, 0, 0, 0);
    ex_memread = 1; ex_rd = 5; id_rs2 = 5;
    step("load_use", mk(5'b00111, 0, 3'b010, 0, 0), 1, 0, 0);
    clear_in();
    step("after_lu", NORM, 2, 1, 0);
    ex_memread = 1; ex_rd = 0;
    step("lu_rd0", NORM, 3, 1, 0);
    clear_in();
    step("after_rd0", NORM, 4, 1, 0);
    ex_branch_taken = 1; id_halt = 1;
    step("br_halt", mk(5'b11111, 1, 3'b110, 0, 0), 5, 1, 0);
    clear_in();
    step("after_br", NORM, 6, 1, 1);
    mem_access = 1; dmem_ready = 0;
    step("ms1", mk(5'b00001, 0, 3'b001, 1, 0), 7, 1, 1);
    ex_branch_taken = 1;
    step("ms2_br", mk(5'b00001, 0, 3'b001, 1, 0), 8, 2, 1);
    step("ms3_br", mk(5'b00001, 0, 3'b001, 1, 0), 9, 3, 1);
    dmem_ready = 1;
    step("ms_done_br", mk(5'b11111, 1, 3'b110, 1, 0), 10, 4, 1);
    clear_in();
    step("after_ms", NORM, 11, 4, 2);
    id_halt = 1;
    step("halt_id", mk(5'b11111, 0, 3'b100, 0, 0), 12, 4, 2);
    clear_in();
    ex_branch_taken = 1; ex_memread = 1; ex_rd = 5; id_rs2 = 5;
    step("drain1", mk(5'b01111, 0, 3'b100, 0, 0), 13, 4, 2);
    clear_in();
    step("drain2", mk(5'b01111, 0, 3'b100, 0, 0), 14, 4, 2);
    wb_halt = 1;
    step("drain3", mk(5'b01111, 0, 3'b100, 0, 0), 15, 4, 2);
    clear_in();
    mem_access = 1; dmem_ready = 0;
    step("halted1", mk(5'b00000, 0, 3'b000, 0, 1), 16, 4, 2);
    ex_branch_taken = 1; id_halt = 1;
    step("halted2", mk(5'b00000, 0, 3'b000, 0, 1), 16, 4, 2);
    reset = 1;
    @(posedge clk); #1;
    step("reset_halted", RSTV, 0, 0, 0);
    reset = 0; clear_in();
    id_halt = 1;
    step("halt_id2", mk(5'b11111, 0, 3'b100, 0, 0), 0, 0, 0);
    clear_in();
    mem_access = 1; dmem_ready = 0;
    step("drain_ms1", mk(5'b00001, 0, 3'b101, 1, 0), 1, 0, 0);
    step("drain_ms2", mk(5'b00001, 0, 3'b101, 1, 0), 2, 1, 0);
    reset = 1;
    step("reset_drain", RSTV, 3, 2, 0);
    reset = 0; clear_in();
    step("run_after_rst", NORM, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
